// File: rtl/busca_pkg.sv
// rtl/busca_pkg.sv - shared types and sizing helpers for the instruction fetch unit
package busca_pkg;

    typedef enum logic {
        BUSCA = 1'b0,
        DRENA = 1'b1
    } estado_t;

    localparam int LARGURA_PADRAO = 32;

    // One extra bit beyond the index so that full and empty are distinguishable.
    function automatic int largura_ptr(input int prof);
        return $clog2(prof) + 1;
    endfunction

endpackage

// File: rtl/fila_reserva.sv
// rtl/fila_reserva.sv - in-order reserve/fill/pop queue with single-cycle flush
module fila_reserva import busca_pkg::*; #(
    parameter int PROF_FILA = 4,
    parameter int LARGURA   = LARGURA_PADRAO,
    localparam int PW       = largura_ptr(PROF_FILA)
) (
    input  logic               clock,
    input  logic               reseta_n,
    input  logic               flush,
    input  logic               reserva,
    input  logic [LARGURA-1:0] reserva_endereco,
    input  logic               preenche_en,
    input  logic [LARGURA-1:0] preenche_dado,
    input  logic               pop,
    output logic [PW-1:0]      reservadas,
    output logic [PW-1:0]      pendentes,
    output logic               cab_cheia,
    output logic               cab_vazia,
    output logic [LARGURA-1:0] cab_endereco,
    output logic [LARGURA-1:0] cab_dado
);

    localparam int IW = PW - 1;

    logic [PW-1:0]        cabeca_q, cabeca_d;
    logic [PW-1:0]        preenche_q, preenche_d;
    logic [PW-1:0]        emissao_q, emissao_d;
    logic [PROF_FILA-1:0] cheia_q, cheia_d;
    logic [LARGURA-1:0]   endereco_q [PROF_FILA];
    logic [LARGURA-1:0]   dado_q     [PROF_FILA];

    always_comb begin
        cabeca_d   = cabeca_q;
        preenche_d = preenche_q;
        emissao_d  = emissao_q;
        cheia_d    = cheia_q;
        if (flush) begin
            cabeca_d   = '0;
            preenche_d = '0;
            emissao_d  = '0;
            cheia_d    = '0;
        end else begin
            if (reserva) begin
                cheia_d[emissao_q[IW-1:0]] = 1'b0;
                emissao_d                  = emissao_q + PW'(1);
            end
            if (preenche_en) begin
                cheia_d[preenche_q[IW-1:0]] = 1'b1;
                preenche_d                  = preenche_q + PW'(1);
            end
            if (pop) begin
                cheia_d[cabeca_q[IW-1:0]] = 1'b0;
                cabeca_d                  = cabeca_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reseta_n) begin
        if (!reseta_n) begin
            cabeca_q   <= '0;
            preenche_q <= '0;
            emissao_q  <= '0;
            cheia_q    <= '0;
        end else begin
            cabeca_q   <= cabeca_d;
            preenche_q <= preenche_d;
            emissao_q  <= emissao_d;
            cheia_q    <= cheia_d;
        end
    end

    // Payload storage needs no reset: cheia_q gates every read of it.
    always_ff @(posedge clock) begin
        if (reserva && !flush) begin
            endereco_q[emissao_q[IW-1:0]] <= reserva_endereco;
        end
        if (preenche_en && !flush) begin
            dado_q[preenche_q[IW-1:0]] <= preenche_dado;
        end
    end

    assign reservadas   = emissao_q - cabeca_q;
    assign pendentes    = emissao_q - preenche_q;
    assign cab_cheia    = cheia_q[cabeca_q[IW-1:0]];
    assign cab_vazia    = (cabeca_q == emissao_q);
    assign cab_endereco = endereco_q[cabeca_q[IW-1:0]];
    assign cab_dado     = dado_q[cabeca_q[IW-1:0]];

endmodule

// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - fetch unit: issues PC reads, buffers words, drains wrong-path data
module busca_instrucao import busca_pkg::*; #(
    parameter int PROF_FILA = 4,
    parameter int LARGURA   = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reseta_n,
    input  logic [LARGURA-1:0] pc_endereco,
    input  logic               jump,
    output logic               pc_espera,
    output logic               mem_req,
    output logic [LARGURA-1:0] mem_endereco,
    input  logic               mem_ack,
    input  logic               mem_valido,
    input  logic [LARGURA-1:0] mem_dado,
    output logic               inst_valida,
    output logic [LARGURA-1:0] inst,
    output logic [LARGURA-1:0] inst_endereco,
    input  logic               inst_pronta,
    output logic               erro_protocolo
);

    localparam int PW = largura_ptr(PROF_FILA);

    estado_t       estado_q, estado_d;
    logic [PW-1:0] descarte_q, descarte_d;
    logic          erro_q, erro_d;
    logic          ativo_q;

    logic [PW-1:0] reservadas, pendentes;
    logic          cab_cheia, cab_vazia;
    logic          tem_pendente, aceita, preenche_en, pop;

    fila_reserva #(
        .PROF_FILA (PROF_FILA),
        .LARGURA   (LARGURA)
    ) u_fila (
        .clock            (clock),
        .reseta_n         (reseta_n),
        .flush            (jump),
        .reserva          (aceita),
        .reserva_endereco (pc_endereco),
        .preenche_en      (preenche_en),
        .preenche_dado    (mem_dado),
        .pop              (pop),
        .reservadas       (reservadas),
        .pendentes        (pendentes),
        .cab_cheia        (cab_cheia),
        .cab_vazia        (cab_vazia),
        .cab_endereco     (inst_endereco),
        .cab_dado         (inst)
    );

    // ativo_q keeps mem_req low while reset is held and for the release cycle.
    assign mem_req      = ativo_q && (estado_q == BUSCA) && !jump && (reservadas < PW'(PROF_FILA));
    assign aceita       = mem_req && mem_ack;
    assign pc_espera    = !aceita;
    assign mem_endereco = pc_endereco;

    assign tem_pendente = (pendentes != '0);
    assign preenche_en  = (estado_q == BUSCA) && mem_valido && tem_pendente && !jump;
    assign inst_valida  = cab_cheia && !cab_vazia && !jump;
    assign pop          = inst_valida && inst_pronta;

    always_comb begin
        estado_d   = estado_q;
        descarte_d = descarte_q;
        erro_d     = erro_q;
        case (estado_q)
            BUSCA: begin
                if (mem_valido && !tem_pendente) begin
                    erro_d = 1'b1;
                end
                // A response landing in the jump cycle is itself wrong-path and already consumed.
                if (jump) begin
                    descarte_d = pendentes - {{(PW-1){1'b0}}, (mem_valido && tem_pendente)};
                    if (descarte_d != '0) begin
                        estado_d = DRENA;
                    end
                end
            end
            DRENA: begin
                if (mem_valido) begin
                    if (descarte_q == '0) begin
                        erro_d = 1'b1;
                    end else begin
                        descarte_d = descarte_q - PW'(1);
                        if (descarte_q == PW'(1)) begin
                            estado_d = BUSCA;
                        end
                    end
                end
            end
            default: estado_d = BUSCA;
        endcase
    end

    always_ff @(posedge clock or negedge reseta_n) begin
        if (!reseta_n) begin
            estado_q   <= BUSCA;
            descarte_q <= '0;
            erro_q     <= 1'b0;
            ativo_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            descarte_q <= descarte_d;
            erro_q     <= erro_d;
            ativo_q    <= 1'b1;
        end
    end

    assign erro_protocolo = erro_q;

endmodule
